pipe_stage_reg: RTL and testbench

Parametrised, handshaked pipeline stage register. It is the successor to the fixed IF/ID register and is used between any two stages of the RV32E core. It carries a generic payload plus an instruction field, tracks per-entry valid/poison state, and substitutes a NOP into the instruction field when it emits a bubble. Downstream backpressure uses valid/ready. Flush is synchronous. An optional skid entry registers the ready path, and a saturating stall counter supports performance debug.

---
 rtl/pipe_stage_reg.sv | 92 +++++++++
 tb/tb_pipe_stage_reg.sv | 127 ++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline stage register with bubble NOP, flush, stall counter; PIPE_STAGE_SKID_EN adds a skid entry
module pipe_stage_reg #(
  parameter int PAYLOAD_W = 64,
  parameter int INSN_W = 32,
  parameter logic [INSN_W-1:0] NOP = INSN_W'(32'h0000_0013),
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_invalid,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [INSN_W-1:0]    in_insn,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_invalid,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [INSN_W-1:0]    out_insn,
  output logic [CNT_W-1:0]     stall_cnt
);
  logic valid_q, valid_d, inv_q, inv_d, head_free, accept, take_skid, load, src_inv;
  logic [PAYLOAD_W-1:0] payload_q, payload_d, src_payload;
  logic [INSN_W-1:0] insn_q, insn_d, src_insn;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign head_free = !valid_q | out_ready;
  assign accept = in_valid & in_ready & !flush;
  assign load = !flush & (take_skid | (head_free & accept));
`ifdef PIPE_STAGE_SKID_EN
  logic s_valid_q, s_valid_d, s_inv_q, s_inv_d;
  logic [PAYLOAD_W-1:0] s_payload_q, s_payload_d;
  logic [INSN_W-1:0] s_insn_q, s_insn_d;
  assign in_ready = !reset & !s_valid_q;
  assign take_skid = head_free & s_valid_q;
  assign src_inv = take_skid ? s_inv_q : in_invalid;
  assign src_payload = take_skid ? s_payload_q : in_payload;
  assign src_insn = take_skid ? s_insn_q : in_insn;
  always_comb begin
    s_valid_d = !flush & (s_valid_q ? !head_free : accept & !head_free);
    s_inv_d = (accept & !head_free) ? in_invalid : s_inv_q;
    s_payload_d = (accept & !head_free) ? in_payload : s_payload_q;
    s_insn_d = (accept & !head_free) ? in_insn : s_insn_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s_valid_q <= 1'b0;
      s_inv_q <= 1'b0;
      s_payload_q <= '0;
      s_insn_q <= '0;
    end else begin
      s_valid_q <= s_valid_d;
      s_inv_q <= s_inv_d;
      s_payload_q <= s_payload_d;
      s_insn_q <= s_insn_d;
    end
  end
`else
  assign in_ready = !reset & head_free;
  assign take_skid = 1'b0;
  assign src_inv = in_invalid;
  assign src_payload = in_payload;
  assign src_insn = in_insn;
`endif
  always_comb begin
    valid_d = !flush & (head_free ? (take_skid | accept) : 1'b1);
    inv_d = load ? src_inv : inv_q;
    payload_d = load ? src_payload : payload_q;
    insn_d = load ? src_insn : insn_q;
    cnt_d = (valid_q & !out_ready & !flush & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      inv_q <= 1'b0;
      payload_q <= '0;
      insn_q <= NOP;
      cnt_q <= '0;
    end else begin
      valid_q <= valid_d;
      inv_q <= inv_d;
      payload_q <= payload_d;
      insn_q <= insn_d;
      cnt_q <= cnt_d;
    end
  end
  assign out_valid = valid_q;
  assign out_invalid = !valid_q | inv_q;
  assign out_payload = payload_q;
  assign out_insn = out_invalid ? NOP : insn_q;
  assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed self-checking bench for pipe_stage_reg in base or skid build
module tb_pipe_stage_reg;
  logic clk = 0, reset, in_valid, in_ready, in_invalid, flush, out_valid, out_ready, out_invalid;
  logic [63:0] in_payload, out_payload;
  logic [31:0] in_insn, out_insn;
  logic [3:0] stall_cnt;
  int n_cmp = 0, n_bad = 0;
  pipe_stage_reg #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_invalid(in_invalid), .in_payload(in_payload), .in_insn(in_insn),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_invalid(out_invalid), .out_payload(out_payload), .out_insn(out_insn),
    .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic v, input logic inv, input logic [31:0] insn, input logic [63:0] pl);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".out_invalid"}, 64'(out_invalid), 64'(inv));
    chk({tag, ".out_insn"}, 64'(out_insn), 64'(insn));
    chk({tag, ".out_payload"}, out_payload, pl);
  endtask
  initial begin
    reset = 1; in_valid = 0; in_invalid = 0; in_payload = 0; in_insn = 0; flush = 0; out_ready = 1;
    #1;
    chk("rst.in_ready", 64'(in_ready), 64'd0);
    repeat (3) tick();
    reset = 0;
    #1;
    chk_out("rst", 0, 1, 32'h13, 64'd0);
    chk("rst.stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst.in_ready_after", 64'(in_ready), 64'd1);
    in_valid = 1; in_insn = 32'h00500093; in_payload = 64'd1;
    tick();
    chk_out("s1", 1, 0, 32'h00500093, 64'd1);
    in_insn = 32'h00A00113; in_payload = 64'd2;
    tick();
    chk_out("s2", 1, 0, 32'h00A00113, 64'd2);
    in_insn = 32'h00F00193; in_payload = 64'd3;
    tick();
    chk_out("s3", 1, 0, 32'h00F00193, 64'd3);
    in_valid = 0;
    tick();
    chk_out("drain", 0, 1, 32'h13, 64'd3);
    in_valid = 1; in_invalid = 1; in_insn = 32'hDEADBEEF; in_payload = 64'h1234;
    tick();
    chk_out("poison", 1, 1, 32'h13, 64'h1234);
    in_invalid = 0; in_insn = 32'h00200113; in_payload = 64'h10;
    tick();
    chk_out("fill", 1, 0, 32'h00200113, 64'h10);
    out_ready = 0; in_insn = 32'h00300193; in_payload = 64'h20;
    #1;
`ifdef PIPE_STAGE_SKID_EN
    chk("stall.in_ready0", 64'(in_ready), 64'd1);
`else
    chk("stall.in_ready0", 64'(in_ready), 64'd0);
`endif
    tick();
    in_valid = 0;
    chk("stall.in_ready1", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) tick();
    chk_out("stall", 1, 0, 32'h00200113, 64'h10);
    chk("stall.cnt", 64'(stall_cnt), 64'd4);
    chk("stall.in_ready", 64'(in_ready), 64'd0);
    out_ready = 1;
    #1;
`ifdef PIPE_STAGE_SKID_EN
    chk("release.in_ready", 64'(in_ready), 64'd0);
    tick();
    chk_out("skid_head", 1, 0, 32'h00300193, 64'h20);
    tick();
    chk_out("skid_drain", 0, 1, 32'h13, 64'h20);
`else
    chk("release.in_ready", 64'(in_ready), 64'd1);
    tick();
    chk_out("release", 0, 1, 32'h13, 64'h10);
`endif
    chk("release.cnt", 64'(stall_cnt), 64'd4);
    in_valid = 1; in_insn = 32'h00500093; in_payload = 64'h5;
    tick();
    chk_out("pre_flush", 1, 0, 32'h00500093, 64'h5);
    flush = 1; in_insn = 32'h00100093; in_payload = 64'h6;
    #1;
    chk("flush.in_ready", 64'(in_ready), 64'd1);
    tick();
    flush = 0; in_valid = 0;
    chk("flush.out_valid", 64'(out_valid), 64'd0);
    chk("flush.out_insn", 64'(out_insn), 64'h13);
    tick();
    chk("post_flush.out_valid", 64'(out_valid), 64'd0);
    chk("post_flush.out_insn", 64'(out_insn), 64'h13);
    in_valid = 1; in_insn = 32'h00700393; in_payload = 64'h7;
    tick();
    out_ready = 0; flush = 1; in_valid = 0;
    tick();
    flush = 0;
    chk("flush_stall.out_valid", 64'(out_valid), 64'd0);
    chk("flush_stall.cnt", 64'(stall_cnt), 64'd4);
    reset = 1; out_ready = 1;
    tick();
    reset = 0;
    #1;
    chk("rst2.cnt", 64'(stall_cnt), 64'd0);
    in_valid = 1; in_insn = 32'h00800413; in_payload = 64'h8;
    tick();
    in_valid = 0; out_ready = 0;
    for (int i = 0; i < 14; i++) tick();
    chk("sat.14", 64'(stall_cnt), 64'd14);
    tick();
    chk("sat.15", 64'(stall_cnt), 64'd15);
    for (int i = 0; i < 5; i++) tick();
    chk("sat.20", 64'(stall_cnt), 64'd15);
    chk_out("sat.hold", 1, 0, 32'h00800413, 64'h8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
